// File: rtl/encoder_4x2_hs_pkg.sv
// Shared types for the 4:2 handshake encoder.
// Buffer states, widths and the buffered entry layout.
package encoder_pkg;

    localparam int CODE_W = 2;
    localparam int IN_W   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] y;
        logic              v;
        logic              err;
    } entry_t;

endpackage

// File: rtl/encoder_4x2_hs_if.sv
// Valid/ready bundle for the 4:2 encoder.
// master drives words in and takes codes out; slave is the encoder.
interface encoder_4x2_hs_if;
    import encoder_pkg::*;

    logic [IN_W-1:0]   D;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] Y;
    logic              V;
    logic              Err;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output D, in_valid, out_ready,
        input  in_ready, Y, V, Err, out_valid
    );

    modport slave (
        input  D, in_valid, out_ready,
        output in_ready, Y, V, Err, out_valid
    );

endinterface

// File: rtl/encoder_4x2_core.sv
// Combinational 4:2 priority encoder.
// Also flags empty (V low) and multi-hot (Err) words.
module encoder_4x2_core
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic [IN_W-1:0]   D,
    output logic [CODE_W-1:0] Y,
    output logic              V,
    output logic              Err
);

    // Pick the winning set bit from the chosen end of the word.
    always_comb begin
        Y = '0;
        if (PRIORITY_HIGH) begin
            if (D[3])      Y = 2'd3;
            else if (D[2]) Y = 2'd2;
            else if (D[1]) Y = 2'd1;
            else           Y = 2'd0;
        end else begin
            if (D[0])      Y = 2'd0;
            else if (D[1]) Y = 2'd1;
            else if (D[2]) Y = 2'd2;
            else if (D[3]) Y = 2'd3;
            else           Y = 2'd0;
        end
    end

    assign V   = |D;
    assign Err = ($countones(D) > 1);

endmodule

// File: rtl/encoder_4x2_hs.sv
// Registered 4:2 priority encoder with main+skid output buffer.
// in_ready comes only from En and registered state.
module encoder_4x2_hs
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 En,
    encoder_4x2_hs_if.slave      bus,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t state_q, state_d;
    entry_t main_q, skid_q, enc;
    logic   accept, drain;
    logic   load_main, load_skid, move_skid;

    encoder_4x2_core #(
        .PRIORITY_HIGH(PRIORITY_HIGH)
    ) u_core (
        .D  (bus.D),
        .Y  (enc.y),
        .V  (enc.v),
        .Err(enc.err)
    );

    assign bus.in_ready  = En & ~rst & (state_q != TWO);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.Y         = main_q.y;
    assign bus.V         = main_q.v;
    assign bus.Err       = main_q.err;

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = bus.out_valid & bus.out_ready;

    // Buffer next state and entry load selects.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (!accept && drain) begin
                    state_d   = EMPTY;
                end else if (accept && drain) begin
                    load_main = 1'b1;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d   = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; reset drops both entries.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Main and skid entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)      main_q <= enc;
            else if (move_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= enc;
        end
    end

    // Saturating count of accepted multi-hot words.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && enc.err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_encoder_4x2_hs.sv
// Directed bench for encoder_4x2_hs.
// Three instances share stimulus: high priority, low priority, 2-bit counter.
module tb_encoder_4x2_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] d;
    logic       in_valid;
    logic       out_ready;

    logic [7:0] cnt_hi;
    logic [7:0] cnt_lo;
    logic [1:0] cnt_sat;

    int total = 0;
    int bad   = 0;

    encoder_4x2_hs_if ih ();
    encoder_4x2_hs_if il ();
    encoder_4x2_hs_if is ();

    assign ih.D = d;
    assign il.D = d;
    assign is.D = d;
    assign ih.in_valid = in_valid;
    assign il.in_valid = in_valid;
    assign is.in_valid = in_valid;
    assign ih.out_ready = out_ready;
    assign il.out_ready = out_ready;
    assign is.out_ready = out_ready;

    encoder_4x2_hs #(.PRIORITY_HIGH(1'b1), .ERR_CNT_W(8)) u_hi (
        .clk(clk), .rst(rst), .En(en), .bus(ih), .err_count(cnt_hi)
    );
    encoder_4x2_hs #(.PRIORITY_HIGH(1'b0), .ERR_CNT_W(8)) u_lo (
        .clk(clk), .rst(rst), .En(en), .bus(il), .err_count(cnt_lo)
    );
    encoder_4x2_hs #(.PRIORITY_HIGH(1'b1), .ERR_CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .En(en), .bus(is), .err_count(cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] words [4];
    logic [3:0] mh    [5];
    logic [1:0] mh_hi [5];
    logic [1:0] mh_lo [5];

    initial begin
        words[0] = 4'b0001; words[1] = 4'b0010;
        words[2] = 4'b0100; words[3] = 4'b1000;
        mh[0] = 4'b1111; mh_hi[0] = 2'd3; mh_lo[0] = 2'd0;
        mh[1] = 4'b0110; mh_hi[1] = 2'd2; mh_lo[1] = 2'd1;
        mh[2] = 4'b0011; mh_hi[2] = 2'd1; mh_lo[2] = 2'd0;
        mh[3] = 4'b1100; mh_hi[3] = 2'd3; mh_lo[3] = 2'd2;
        mh[4] = 4'b0101; mh_hi[4] = 2'd2; mh_lo[4] = 2'd0;

        rst = 1'b1; en = 1'b0; d = 4'b0000;
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        en = 1'b1;
        step();
        chk("rst_in_ready", ih.in_ready, 0);
        chk("rst_out_valid", ih.out_valid, 0);
        chk("rst_Y", ih.Y, 0);
        chk("rst_V", ih.V, 0);
        chk("rst_Err", ih.Err, 0);
        chk("rst_cnt", cnt_hi, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_idle", ih.in_ready, 1);

        // one-hot stream, one per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = words[i];
            step();
            chk("stream_ov", ih.out_valid, 1);
            chk("stream_Y", ih.Y, i);
            chk("stream_V", ih.V, 1);
            chk("stream_Err", ih.Err, 0);
        end
        in_valid = 1'b0;
        step();
        chk("stream_empty", ih.out_valid, 0);

        // zero word
        in_valid = 1'b1; d = 4'b0000;
        step();
        in_valid = 1'b0;
        chk("zero_ov", ih.out_valid, 1);
        chk("zero_Y", ih.Y, 0);
        chk("zero_V", ih.V, 0);
        chk("zero_Err", ih.Err, 0);
        chk("zero_cnt", cnt_hi, 0);
        step();

        // multi-hot 1010
        in_valid = 1'b1; d = 4'b1010;
        step();
        in_valid = 1'b0;
        chk("mh_hi_Y", ih.Y, 3);
        chk("mh_hi_Err", ih.Err, 1);
        chk("mh_hi_cnt", cnt_hi, 1);
        chk("mh_lo_Y", il.Y, 1);
        chk("mh_lo_Err", il.Err, 1);
        step();

        // backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; d = 4'b0001;
        step();
        d = 4'b0100;
        chk("bp_ready1", ih.in_ready, 1);
        chk("bp_Y1", ih.Y, 0);
        step();
        d = 4'b1000;
        chk("bp_ready2", ih.in_ready, 0);
        chk("bp_Y2", ih.Y, 0);
        chk("bp_ov2", ih.out_valid, 1);
        step();
        chk("bp_ready3", ih.in_ready, 0);
        chk("bp_Y3", ih.Y, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_drain_ov", ih.out_valid, 1);
        chk("bp_drain_Y", ih.Y, 2);
        step();
        chk("bp_drain_end", ih.out_valid, 0);

        // En low blocks accepts
        en = 1'b0; in_valid = 1'b1; d = 4'b0010;
        #1;
        chk("en_ready", ih.in_ready, 0);
        step();
        chk("en_ov", ih.out_valid, 0);
        en = 1'b1;

        // saturating counter, 5 multi-hot words
        for (int i = 0; i < 5; i++) begin
            d = mh[i];
            step();
            chk("sat_hi_Y", ih.Y, mh_hi[i]);
            chk("sat_lo_Y", il.Y, mh_lo[i]);
            chk("sat_cnt2", cnt_sat, (i + 2 > 3) ? 3 : i + 2);
            chk("sat_cnt8", cnt_hi, i + 2);
        end
        in_valid = 1'b0;
        step();

        // reset while TWO
        out_ready = 1'b0; in_valid = 1'b1; d = 4'b0001;
        step();
        d = 4'b0010;
        step();
        chk("two_ready", ih.in_ready, 0);
        rst = 1'b1; d = 4'b1111;
        #1;
        chk("rst_mid_ready", ih.in_ready, 0);
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("rst_mid_ov", ih.out_valid, 0);
        chk("rst_mid_cnt", cnt_hi, 0);
        chk("rst_mid_cnt2", cnt_sat, 0);
        step();
        chk("rst_mid_ov2", ih.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_4x2_hs.md
# encoder_4x2_hs

Registered 4-to-2 priority encoder with valid/ready handshake on both sides. It is the inverse companion of the team's 2:4 decoder: it turns a 4-bit request/one-hot word back into a 2-bit code plus a valid flag (`V`), flags multi-hot inputs, and counts them. A two-entry output buffer (main plus skid) lets it sit between pipelined producers and consumers without combinational ready paths.

## Interface
- `PRIORITY_HIGH`, default 1. 1: highest set bit index wins. 0: lowest set bit index wins.
- `ERR_CNT_W`, default 8. Width of the saturating error counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `En` in 1: enable. When 0, `in_ready` = 0 and no input is accepted; the output side keeps draining.
- `D` in 4: input word.
- `in_valid` in 1: `D` is valid.
- `in_ready` out 1: block can accept; equals `En & (state != TWO)`.
- `Y` out 2: encoded index.
- `V` out 1: at least one bit of the encoded word was set.
- `Err` out 1: the encoded word had more than one bit set.
- `out_valid` out 1: `Y`/`V`/`Err` are valid.
- `out_ready` in 1: downstream accepts.
- `err_count` out `ERR_CNT_W`: number of accepted words with `Err` = 1; saturating.

## Operation
- Accept happens when `in_valid & in_ready`. Drain happens when `out_valid & out_ready`.
- Encoding with `PRIORITY_HIGH` = 1:
  - 1xxx -> 11
  - 01xx -> 10
  - 001x -> 01
  - 0001 -> 00
  - 0000 -> `Y` = 00, `V` = 0
- `PRIORITY_HIGH` = 0 mirrors this: lowest set bit wins.
- `Err` = popcount(`D`) > 1. `V` = |`D`.
- Round trip: driving the 2:4 decoder with `D` = `Y` and `En` = `V` reproduces any one-hot or zero input word.
- Buffer states are EMPTY, ONE and TWO. The main entry drives the outputs; the skid entry holds the overflow word.
  - EMPTY: accept -> ONE (word loaded into main).
  - ONE, accept without drain -> TWO (word loaded into skid).
  - ONE, drain without accept -> EMPTY.
  - ONE, accept and drain -> ONE (main reloaded with the new word).
  - TWO: `in_ready` = 0. Drain -> ONE (skid moves to main).
- `out_valid` = (state != EMPTY).
- `err_count` increments on the accept edge of any word with `Err` = 1. It holds at all-ones and does not wrap.

## Timing
- Latency: a word accepted at edge N appears on the outputs after edge N, i.e. `out_valid` is high in cycle N+1.
- Throughput is 1 word/cycle while `out_ready` is held high.
- While `out_valid & !out_ready`, `Y`/`V`/`Err` are stable.
- `in_ready` depends only on `En` and registered state. There is no combinational path from `out_ready` to `in_ready`.
- `En` falling in the middle of a stream blocks further accepts from the next cycle's evaluation. Buffered words are still delivered.
- Reset values: state EMPTY, `out_valid` 0, `Y` 00, `V` 0, `Err` 0, `err_count` 0. `in_ready` is 0 while `rst` is high.
  - A reset asserted mid-stream discards both entries. A word presented in the reset cycle is not accepted.
- The error count is taken at accept time, not at drain time.

## Structure
- Package `encoder_pkg`:
  - state enum: EMPTY, ONE, TWO
  - localparam `CODE_W` = 2
  - localparam `IN_W` = 4
- Sub-module `encoder_4x2_core`: purely combinational; inputs `D` and `PRIORITY_HIGH`; outputs `Y`, `V`, `Err`.
- The top level holds the buffer FSM, the two entry registers and the counter.

## Test plan
- Reset, then `En`=1, `out_ready`=1, stream 0001, 0010, 0100, 1000 back-to-back -> `Y` = 00, 01, 10, 11 with `V`=1 and `Err`=0, one per cycle, first output one cycle after the first accept.
- `D`=0000 accepted -> `Y`=00, `V`=0, `Err`=0, and `err_count` is unchanged.
- Multi-hot input 1010:
  - with `PRIORITY_HIGH`=1 -> `Y`=11, `Err`=1, `err_count`=1
  - with `PRIORITY_HIGH`=0 -> `Y`=01
- Backpressure: hold `out_ready`=0 and offer 3 words -> two accepted, `in_ready` drops to 0, `Y` stays frozen on the first word. Release -> words drain in order with none lost or duplicated.
- `ERR_CNT_W`=2, accept 5 multi-hot words -> `err_count` reaches 3 and holds at 3.
- Assert `rst` for one cycle while in state TWO with `in_valid`=1 -> next cycle `out_valid`=0, `err_count`=0, and nothing from the reset cycle is emitted.
